dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
Multi-cycle data-memory access unit that sits directly downstream of the core's MEM stage. It replaces the core's ideal single-cycle data memory port with a handshaked word-addressed SRAM/bus interface. It performs byte-lane steering, load extraction and extension, and misalignment checks. It holds the core with a stall signal until the access completes.

Parameters:
ADDR_WIDTH, 32, core byte address width.
TIMEOUT_CYCLES, 255, max cycles allowed in REQ or WAIT_R before the access is aborted with bus_err (8-bit counter).

Ports:
clk  input  1  clock; all state updates on its rising edge.
rstn  input  1  reset; synchronous, active-low.
mem_read  input  1  core load request (level, held while stall=1).
mem_write  input  1  core store request (level, held while stall=1).
maskmode  input  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 reserved.
sext  input  1  funct3[2]: 0 = sign-extend load, 1 = zero-extend load (LBU/LHU).
address  input  ADDR_WIDTH  byte address (ALU result).
write_data  input  32  store data (rs2 value).
read_data  output  32  extended load result; valid in DONE.
stall  output  1  high while the core must not advance.
misalign_err  output  1  one-cycle pulse in DONE for a misaligned or reserved access.
bus_err  output  1  one-cycle pulse in DONE on timeout.
mem_req  output  1  bus request, registered.
mem_we  output  1  1 = write, registered.
mem_addr  output  ADDR_WIDTH-2  word address = address[ADDR_WIDTH-1:2], registered.
mem_be  output  4  byte enables, registered.
mem_wdata  output  32  lane-steered store data, registered.
mem_gnt  input  1  bus accepted request this cycle.
mem_rvalid  input  1  read data valid; no earlier than the cycle after mem_gnt.
mem_rdata  input  32  read word.

Behaviour:
- Reset (rstn=0 at a clk edge): state to IDLE; timeout counter to 0; all outputs to 0 (stall is combinational and follows the rule below). This applies mid-access as well: mem_req drops on the next cycle, and a late mem_rvalid is ignored.
- stall = (mem_read | mem_write) & (state != DONE). It is combinational.
- If mem_read and mem_write are both high, the request is treated as a write.
- States:
  - IDLE: with a request, latch maskmode, sext, address[1:0] and the write flag. If the access is aligned, go to REQ and drive mem_req/mem_we/mem_addr/mem_be/mem_wdata registered. If it is misaligned, go to DONE with misalign_err and no bus activity.
  - REQ: hold mem_req and its fields stable until mem_gnt. On mem_gnt, drop mem_req; a write goes to DONE and a read goes to WAIT_R.
  - WAIT_R: on mem_rvalid, capture the extracted word into read_data and go to DONE.
  - DONE: drives stall=0 for exactly one cycle, then returns to IDLE unconditionally. A new request is processed starting from IDLE.
- Misaligned or reserved access: maskmode 11; half with address[0]=1; word with address[1:0]!=0.
- Timeout: the counter runs in REQ and WAIT_R and clears on every state change. When it reaches TIMEOUT_CYCLES, go to DONE with bus_err=1, read_data=0 and mem_req=0.
- Store steering:
  - byte: be = 0001 << a[1:0]; wdata = byte replicated x4.
  - half: be = 0011 (a[1]=0) or 1100 (a[1]=1); wdata = half replicated x2.
  - word: be = 1111; wdata unchanged.
- Load extraction: select the byte or half by the latched a[1:0], then extend to 32 bits. sext=0 gives sign extension and sext=1 gives zero extension. A word load passes through unchanged. For reads mem_be=1111.
- Minimum latency (stall-high cycles): misaligned 1, write 2 (mem_gnt in the first REQ cycle), read 3 (mem_rvalid in the cycle after mem_gnt).
- Input changes while stall=1 are ignored; the latched copy governs the access.
- read_data holds its last value outside DONE. It is updated only for reads and on timeout.

Test Plan:
1. SW 0xDEADBEEF to addr 0x40, mem_gnt immediate -> one REQ cycle with mem_addr=0x10, be=1111, wdata=DEADBEEF, mem_we=1; stall high 2 cycles, then DONE.
2. LB addr 0x43 with sext=0, mem_rdata=0x80112233, rvalid 2 cycles after gnt -> be=1111, read_data=0xFFFFFF80 in DONE; repeat with sext=1 -> 0x00000080.
3. SH 0x1234_ABCD to addr 0x06 -> be=1100, wdata=0xABCDABCD; LH addr 0x05 -> misalign_err pulse, mem_req never asserted, stall high exactly 1 cycle.
4. LW with mem_gnt held low 255 cycles -> bus_err pulse, read_data=0, mem_req=0 in DONE, then IDLE.
5. rstn=0 during WAIT_R, then mem_rvalid asserted after reset -> state IDLE, all outputs 0, rvalid ignored; the next LW completes normally.
6. Back-to-back SB 0x5A to addr 0x01, then LBU addr 0x01 with memory returning 0x00005A00 -> be=0010, wdata=0x5A5A5A5A; read_data=0x0000005A; each access passes through IDLE.

Source files
------------

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - handshaked data-memory access unit with lane steering and load extension
// Holds the core via stall while one access walks IDLE -> REQ -> (WAIT_R) -> DONE.
module dmem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            maskmode,
  input  logic                  sext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  stall,
  output logic                  misalign_err,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic [1:0]            mode_q;
  logic                  sext_q;
  logic [1:0]            off_q;
  logic                  wr_q;
  logic [31:0]           read_data_q;
  logic                  misalign_err_q;
  logic                  bus_err_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-3:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [31:0]           mem_wdata_q;

  logic                  req_any;
  logic                  misaligned;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_ext;

  assign req_any = mem_read | mem_write;
  assign stall   = req_any & (state_q != DONE);

  // Alignment and store steering are evaluated on the live inputs, only used in IDLE.
  always_comb begin
    misaligned = 1'b0;
    st_be      = 4'b0000;
    st_wdata   = 32'h0;
    case (maskmode)
      2'b00: begin
        st_be    = 4'b0001 << address[1:0];
        st_wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        misaligned = address[0];
        st_be      = address[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{write_data[15:0]}};
      end
      2'b10: begin
        misaligned = |address[1:0];
        st_be      = 4'b1111;
        st_wdata   = write_data;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load extraction uses the latched offset/mode; sext_q=1 selects zero extension.
  always_comb begin
    ld_byte = 8'h0;
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mode_q)
      2'b00:   ld_ext = {{24{~sext_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~sext_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      cnt_q          <= 8'h0;
      mode_q         <= 2'b00;
      sext_q         <= 1'b0;
      off_q          <= 2'b00;
      wr_q           <= 1'b0;
      read_data_q    <= 32'h0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_be_q       <= 4'b0000;
      mem_wdata_q    <= 32'h0;
    end else begin
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= 8'h0;
          if (req_any) begin
            mode_q <= maskmode;
            sext_q <= sext;
            off_q  <= address[1:0];
            wr_q   <= mem_write;
            if (misaligned) begin
              state_q        <= DONE;
              misalign_err_q <= 1'b1;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= mem_write;
              mem_addr_q  <= address[ADDR_WIDTH-1:2];
              mem_be_q    <= mem_write ? st_be : 4'b1111;
              mem_wdata_q <= mem_write ? st_wdata : 32'h0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= 8'h0;
            state_q   <= wr_q ? DONE : WAIT_R;
          end else if (cnt_q == TO_LAST) begin
            mem_req_q   <= 1'b0;
            cnt_q       <= 8'h0;
            bus_err_q   <= 1'b1;
            read_data_q <= 32'h0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            read_data_q <= ld_ext;
            cnt_q       <= 8'h0;
            state_q     <= DONE;
          end else if (cnt_q == TO_LAST) begin
            cnt_q       <= 8'h0;
            bus_err_q   <= 1'b1;
            read_data_q <= 32'h0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        default: begin
          cnt_q   <= 8'h0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign read_data    = read_data_q;
  assign misalign_err = misalign_err_q;
  assign bus_err      = bus_err_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
